instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer_pkg.sv | 23 ++
 rtl/instruction_sequencer_fifo.sv | 53 +++++
 rtl/instruction_sequencer.sv | 101 ++++++++++
 tb/tb_instruction_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction layout,
// opcode and register-select constants, and the sequencer state encoding.
package instruction_sequencer_pkg;

  localparam int unsigned INSTR_W = 13;

  localparam logic [1:0] OP_STORE = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  localparam logic [1:0] REG_A1 = 2'b00;
  localparam logic [1:0] REG_A2 = 2'b01;
  localparam logic [1:0] REG_A3 = 2'b10;
  localparam logic [1:0] REG_A4 = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WAIT_ALU = 2'd2
  } seq_state_t;

endpackage

// File: rtl/instruction_sequencer_fifo.sv
// Instruction buffer: power-of-two depth FIFO with full/empty flags and a
// combinational head output.
module instr_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Buffers 13-bit instructions and issues them one at a time to the memory
// port (load/store) or the ALU (add/multiply), counting retirements.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic [8:0]         mem_addr,
  output logic [1:0]         mem_reg_sel,
  input  logic               mem_ack,
  output logic               alu_start,
  output logic               alu_op,
  input  logic               alu_done,
  output logic               busy,
  output logic [15:0]        retired_count
);

  seq_state_t         state;
  logic [INSTR_W-1:0] head;
  logic [1:0]         head_op;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  // Gating with rst keeps the producer off while the buffer is held in reset.
  assign instr_ready = rst && !fifo_full;
  assign push        = instr_valid && instr_ready;
  assign pop         = (state == IDLE) && !fifo_empty;
  assign busy        = !fifo_empty || (state != IDLE);
  assign head_op     = head[12:11];

  instr_fifo #(
    .WIDTH(INSTR_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (instr),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_reg_sel   <= '0;
      alu_start     <= 1'b0;
      alu_op        <= 1'b0;
      retired_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            if (!head_op[1]) begin
              state       <= WAIT_MEM;
              mem_req     <= 1'b1;
              mem_we      <= (head_op == OP_STORE);
              mem_addr    <= head[8:0];
              mem_reg_sel <= head[10:9];
            end else begin
              state     <= WAIT_ALU;
              alu_start <= 1'b1;
              alu_op    <= head[11];
            end
          end
        end
        WAIT_MEM: begin
          if (mem_ack) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            retired_count <= retired_count + 1'b1;
          end
        end
        WAIT_ALU: begin
          alu_start <= 1'b0;
          // alu_done coinciding with the start pulse belongs to nothing we issued.
          if (alu_done && !alu_start) begin
            state         <= IDLE;
            retired_count <= retired_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer with automatic memory/ALU responders.
module tb_instruction_sequencer;

  typedef struct packed {
    logic       is_mem;
    logic       we;
    logic [8:0] addr;
    logic [1:0] rsel;
    logic       aop;
  } exp_t;

  localparam int unsigned MEM_DLY = 2;
  localparam int unsigned ALU_DLY = 3;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [12:0] instr;
  logic        instr_ready;
  logic        mem_req;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [1:0]  mem_reg_sel;
  logic        mem_ack;
  logic        alu_start;
  logic        alu_op;
  logic        alu_done;
  logic        busy;
  logic [15:0] retired_count;

  int unsigned checks = 0;
  int unsigned failures = 0;
  exp_t        expq[$];

  logic ack_en = 1'b1;
  logic alu_en = 1'b1;
  logic stray_ack = 1'b0;
  logic stray_done = 1'b0;

  instruction_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_reg_sel   (mem_reg_sel),
    .mem_ack       (mem_ack),
    .alu_start     (alu_start),
    .alu_op        (alu_op),
    .alu_done      (alu_done),
    .busy          (busy),
    .retired_count (retired_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [12:0] x);
    exp_t e;
    e.is_mem = !x[12];
    e.we     = (x[12:11] == 2'b00);
    e.addr   = x[8:0];
    e.rsel   = x[10:9];
    e.aop    = x[11];
    return e;
  endfunction

  task automatic push(input logic [12:0] x);
    int unsigned n = 0;
    instr       = x;
    instr_valid = 1'b1;
    while (!instr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      chk("push_timeout", 32'(instr_ready), 1);
    end else begin
      @(posedge clk);
      expq.push_back(model(x));
    end
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((busy || expq.size() != 0) && n < 400);
    if (busy || expq.size() != 0) chk("idle_timeout", 32'(busy), 0);
  endtask

  // Monitor and responder: one negedge process so sampling and driving stay ordered.
  initial begin : monitor
    logic        prev_mem = 1'b0;
    logic        prev_start = 1'b0;
    logic        alu_pend = 1'b0;
    logic        auto_ack;
    logic        auto_done;
    logic [11:0] held = '0;
    int unsigned mem_cyc = 0;
    int unsigned alu_cyc = 0;
    exp_t        e;
    mem_ack  = 1'b0;
    alu_done = 1'b0;
    forever begin
      @(negedge clk);
      auto_ack  = 1'b0;
      auto_done = 1'b0;
      if (!rst) begin
        prev_mem   = 1'b0;
        prev_start = 1'b0;
        alu_pend   = 1'b0;
        mem_cyc    = 0;
      end else begin
        if (prev_start) chk("alu_start_width", 32'(alu_start), 0);
        if (mem_req && !prev_mem) begin
          chk("sb_nonempty_mem", 32'(expq.size() != 0), 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("issue_kind_mem", 32'(e.is_mem), 1);
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_reg_sel", 32'(mem_reg_sel), 32'(e.rsel));
          end
          held = {mem_we, mem_addr, mem_reg_sel};
        end else if (mem_req) begin
          chk("mem_held", 32'({mem_we, mem_addr, mem_reg_sel}), 32'(held));
        end
        if (alu_start) begin
          chk("sb_nonempty_alu", 32'(expq.size() != 0), 1);
          if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("issue_kind_alu", 32'(e.is_mem), 0);
            chk("alu_op", 32'(alu_op), 32'(e.aop));
          end
          alu_pend = 1'b1;
          alu_cyc  = 0;
        end else if (alu_pend && alu_en) begin
          alu_cyc++;
          if (alu_cyc == ALU_DLY) begin
            auto_done = 1'b1;
            alu_pend  = 1'b0;
          end
        end
        if (mem_req && ack_en) begin
          mem_cyc++;
          auto_ack = (mem_cyc == MEM_DLY);
        end else begin
          mem_cyc = 0;
        end
        prev_mem   = mem_req;
        prev_start = alu_start;
      end
      mem_ack  = auto_ack | stray_ack;
      alu_done = auto_done | stray_done;
    end
  end

  initial begin
    rst         = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;

    // Reset state
    #12;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_alu_start", 32'(alu_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_retired", 32'(retired_count), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("ready_after_rst", 32'(instr_ready), 1);
    @(negedge clk);

    // Load A1 from address 0, with latency check
    push(13'b0100000000000);
    chk("lat_edge_n", 32'(mem_req), 0);
    @(posedge clk);
    #1 chk("lat_edge_n1", 32'(mem_req), 1);
    wait_idle();
    chk("retired_load", 32'(retired_count), 1);

    // Stray mem_ack while idle, then a store
    @(negedge clk);
    #2 stray_ack = 1'b1;
    @(negedge clk);
    #2 stray_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("stray_ack_retired", 32'(retired_count), 1);
    chk("stray_ack_busy", 32'(busy), 0);
    chk("stray_ack_req", 32'(mem_req), 0);
    push(13'b0010001000000);
    wait_idle();
    chk("retired_store", 32'(retired_count), 2);

    // Add then multiply
    push(13'b1011111111111);
    push(13'b1100000000000);
    wait_idle();
    chk("retired_alu", 32'(retired_count), 4);

    // Back-pressure: five loads with acks withheld
    ack_en = 1'b0;
    for (int i = 0; i < 5; i++) push(13'(13'b0100000000000 | (13'(i) + 13'h10)));
    chk("full_ready", 32'(instr_ready), 0);
    chk("full_busy", 32'(busy), 1);
    chk("full_pending", 32'(expq.size()), 4);
    @(negedge clk);
    ack_en = 1'b1;
    wait_idle();
    chk("retired_burst", 32'(retired_count), 9);

    // Reset in the middle of an ALU operation with three buffered
    alu_en = 1'b0;
    push(13'b1100000000000);
    push(13'b0100000000001);
    push(13'b0100000000010);
    push(13'b0100000000011);
    @(negedge clk);
    chk("pre_rst_alu_op", 32'(alu_op), 1);
    chk("pre_rst_pending", 32'(expq.size()), 3);
    #2 rst = 1'b0;
    #1;
    expq.delete();
    chk("mid_rst_mem_req", 32'(mem_req), 0);
    chk("mid_rst_mem_we", 32'(mem_we), 0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 0);
    chk("mid_rst_mem_reg_sel", 32'(mem_reg_sel), 0);
    chk("mid_rst_alu_start", 32'(alu_start), 0);
    chk("mid_rst_alu_op", 32'(alu_op), 0);
    chk("mid_rst_retired", 32'(retired_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(instr_ready), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    alu_en = 1'b1;
    @(negedge clk);
    #2 stray_done = 1'b1;
    @(negedge clk);
    #2 stray_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("late_done_busy", 32'(busy), 0);
    chk("late_done_retired", 32'(retired_count), 0);
    chk("late_done_alu_start", 32'(alu_start), 0);

    // retired_count wrap
    @(negedge clk);
    force dut.retired_count = 16'hFFFF;
    #1 release dut.retired_count;
    push(13'b0111000000101);
    wait_idle();
    chk("retired_wrap", 32'(retired_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
